// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64-bit register file write side.
// Latency: n/a (types only). Backpressure: n/a.
// Everything else in the register file imports this package.
package regfile_pkg;
    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    typedef logic [DATA_W-1:0] reg_word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);
endpackage

// File: rtl/regfile_write_bank_if.sv
// Writeback, issue and register-readout signals between the pipeline and the write bank.
// Latency: n/a (wiring only). Backpressure: none; writes and issues are always accepted.
// The master modport is the pipeline side; the slave modport is the write bank.
interface regfile_write_bank_if;
    import regfile_pkg::*;

    logic                       wr_en;
    reg_addr_t                  wr_addr;
    reg_word_t                  wr_data;
    logic                       issue_en;
    reg_addr_t                  issue_addr;
    logic [NUM_REGS*DATA_W-1:0] regs_out;
    logic [NUM_REGS-1:0]        pending;
    logic                       wr_ack;

    modport master (
        output wr_en, wr_addr, wr_data, issue_en, issue_addr,
        input  regs_out, pending, wr_ack
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, issue_en, issue_addr,
        output regs_out, pending, wr_ack
    );
endinterface

// File: rtl/reg_en64.sv
// One 64-bit architectural register: D flop with load enable and async active-low clear.
// Latency: 1 edge from en to q. Backpressure: none; a load is always taken.
// Holds its value whenever en is low.
module reg_en64
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      en,
    input  reg_word_t d,
    output reg_word_t q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the 32 x 64-bit register file: decoded writeback, XZR tie-off, pending-write scoreboard.
// Latency: 1 edge from wr_en/issue_en to regs_out/pending/wr_ack. Backpressure: none, every write and issue is accepted.
// No write-to-read bypass; the pipeline forwards in-flight results itself.
module regfile_write_bank
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    regfile_write_bank_if.slave  bus
);
    reg_word_t           regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] set_v;
    logic [NUM_REGS-1:0] clr_v;
    logic                wr_ack_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        if (k == ZERO_REG) begin : g_zero
            assign regs_q[k] = '0;
        end else begin : g_word
            logic en;
            assign en = bus.wr_en && (bus.wr_addr == reg_addr_t'(k));

            reg_en64 u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (en),
                .d     (bus.wr_data),
                .q     (regs_q[k])
            );
        end
    end

    always_comb begin
        bus.regs_out = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            bus.regs_out[k*DATA_W +: DATA_W] = regs_q[k];
        end
    end

    // XZR never gets a set or clear, so its scoreboard bit stays at its reset value of 0.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (k != ZERO_REG) begin
                set_v[k] = bus.issue_en && (bus.issue_addr == reg_addr_t'(k));
                clr_v[k] = bus.wr_en    && (bus.wr_addr    == reg_addr_t'(k));
            end
        end
    end

    // Set beats clear: a newer producer issued on the edge its predecessor retires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            wr_ack_q  <= 1'b0;
        end else begin
            pending_q <= set_v | (pending_q & ~clr_v);
            wr_ack_q  <= bus.wr_en && (bus.wr_addr != ZERO_ADDR);
        end
    end

    assign bus.pending = pending_q;
    assign bus.wr_ack  = wr_ack_q;
endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed bench for regfile_write_bank: reset, writeback decode, XZR, scoreboard set/clear.
// Expected register and pending values are kept in a small bench-side model.
module tb_regfile_write_bank;
    import regfile_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    reg_word_t           exp_regs [NUM_REGS];
    logic [NUM_REGS-1:0] exp_pend;

    regfile_write_bank_if bus ();

    regfile_write_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < NUM_REGS; k++) begin
            chk($sformatf("%s_r%0d", tag, k), bus.regs_out[k*DATA_W +: DATA_W], exp_regs[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.issue_en = 1'b0;
        bus.issue_addr = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = '0;
        exp_pend = '0;
        idle();

        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check_regs("rst0");
        chk("rst0_pending", 64'(bus.pending), 64'h0);
        chk("rst0_ack", 64'(bus.wr_ack), 64'h0);
        tick();
        tick();
        reset = 1'b1;

        // Fill 0..30, issuing to the same register on each edge so the scoreboard fills too.
        for (int k = 0; k < ZERO_REG; k++) begin
            bus.wr_en      = 1'b1;
            bus.wr_addr    = reg_addr_t'(k);
            bus.wr_data    = 64'h1111111111111111;
            bus.issue_en   = 1'b1;
            bus.issue_addr = reg_addr_t'(k);
            tick();
            exp_regs[k] = 64'h1111111111111111;
        end
        exp_pend = 32'h7FFFFFFF;
        check_regs("fill");
        chk("fill_pending", 64'(bus.pending), 64'(exp_pend));
        chk("fill_ack", 64'(bus.wr_ack), 64'h1);

        // Mid-cycle asynchronous reset with a write still presented.
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = '0;
        exp_pend = '0;
        check_regs("async_rst");
        chk("async_rst_pending", 64'(bus.pending), 64'h0);
        chk("async_rst_ack", 64'(bus.wr_ack), 64'h0);
        idle();
        #1 reset = 1'b1;

        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd20;
        bus.wr_data = 64'h0000010204080001;
        tick();
        exp_regs[20] = 64'h0000010204080001;
        check_regs("wr20");
        chk("wr20_ack", 64'(bus.wr_ack), 64'h1);
        idle();
        tick();
        chk("wr20_ack_drop", 64'(bus.wr_ack), 64'h0);
        check_regs("wr20_hold");

        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd31;
        bus.wr_data = 64'hFFFFFFFFFFFFFFFF;
        tick();
        check_regs("xzr");
        chk("xzr_ack", 64'(bus.wr_ack), 64'h0);
        chk("xzr_pending", 64'(bus.pending), 64'h0);
        idle();

        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd5;
        tick();
        idle();
        chk("iss5", 64'(bus.pending), 64'h20);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("iss5_hold%0d", i), 64'(bus.pending), 64'h20);
        end
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd5;
        bus.wr_data = 64'h00000000DEADBEEF;
        tick();
        idle();
        exp_regs[5] = 64'h00000000DEADBEEF;
        chk("wb5_pending", 64'(bus.pending), 64'h0);
        chk("wb5_ack", 64'(bus.wr_ack), 64'h1);

        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd9;
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 5'd9;
        bus.wr_data    = 64'h1234;
        tick();
        idle();
        exp_regs[9] = 64'h1234;
        chk("set_wins_pending", 64'(bus.pending), 64'h200);
        chk("set_wins_r9", bus.regs_out[9*DATA_W +: DATA_W], 64'h1234);
        check_regs("set_wins");

        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd7;
        tick();
        idle();
        chk("iss7", 64'(bus.pending), 64'h280);

        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd3;
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 5'd7;
        bus.wr_data    = 64'hA5A5_0000_FFFF_C3C3;
        tick();
        idle();
        exp_regs[7] = 64'hA5A5_0000_FFFF_C3C3;
        chk("split_pending", 64'(bus.pending), 64'h208);
        chk("split_ack", 64'(bus.wr_ack), 64'h1);
        check_regs("split");

        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd31;
        tick();
        idle();
        chk("iss31_pending", 64'(bus.pending), 64'h208);
        chk("iss31_bit31", 64'(bus.pending[31]), 64'h0);
        check_regs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
